pc_update_ctrl: RTL and testbench

Multicycle PC-update sequencer. Accepts one PC-update request per instruction from the main control unit and drives the PC source mux selector and PC write enable. Sequential updates and jumps take one cycle; conditional branches take a target-calculation cycle followed by a flag-evaluation cycle. Sits between the main control FSM and the PC register / PC source mux in the datapath.

---
 rtl/pc_update_ctrl.sv | 116 +++++++++++
 tb/tb_pc_update_ctrl.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/pc_update_ctrl.sv
// Multicycle PC-update sequencer: retires one PC-update request per instruction,
// driving the PC source mux and PC write enable (1 cycle for SEQ/JUMP/JR, 2 for branches).
module pc_update_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic [2:0]  req_kind,
  input  logic [1:0]  br_cond,
  input  logic        zero,
  input  logic        gt,
  output logic        req_ready,
  output logic [2:0]  pc_source,
  output logic        pc_write,
  output logic        alu_calc,
  output logic        done,
  output logic        taken,
  output logic [15:0] taken_count
);

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_CALC, S_EVAL} state_t;

  localparam logic [2:0] K_SEQ    = 3'b000;
  localparam logic [2:0] K_JUMP   = 3'b001;
  localparam logic [2:0] K_JR     = 3'b010;
  localparam logic [2:0] K_BRANCH = 3'b011;

  localparam logic [2:0] SRC_PC4    = 3'b000;
  localparam logic [2:0] SRC_ALUOUT = 3'b010;
  localparam logic [2:0] SRC_JUMP   = 3'b011;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [2:0]  r_kind;
  logic [1:0]  r_cond;
  logic [15:0] r_taken_count;
  logic        w_accept;
  logic        w_cond;

  assign w_accept    = req_valid & req_ready;
  assign taken_count = r_taken_count;

  // State register
  always_ff @(posedge clk) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Request latch: data only, a stale value is never decoded outside WRITE/EVAL
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_kind <= req_kind;
      r_cond <= br_cond;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset)
      r_taken_count <= 16'h0000;
    else if (r_state == S_EVAL && w_cond && r_taken_count != 16'hFFFF)
      r_taken_count <= r_taken_count + 16'h0001;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_nxt = (req_kind == K_BRANCH) ? S_CALC : S_WRITE;
      S_WRITE: w_state_nxt = S_IDLE;
      S_CALC:  w_state_nxt = S_EVAL;
      S_EVAL:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    case (r_cond)
      2'b00:   w_cond = zero;
      2'b01:   w_cond = ~zero;
      2'b10:   w_cond = gt;
      default: w_cond = ~gt;
    endcase
  end

  // Output decode; an asserted reset suppresses every strobe in that same cycle
  always_comb begin
    req_ready = 1'b0;
    pc_source = SRC_PC4;
    pc_write  = 1'b0;
    alu_calc  = 1'b0;
    done      = 1'b0;
    taken     = 1'b0;
    if (reset) begin
      case (r_state)
        S_IDLE:  req_ready = 1'b1;
        S_WRITE: begin
          done = 1'b1;
          case (r_kind)
            K_SEQ:   pc_write = 1'b1;
            K_JUMP:  begin pc_write = 1'b1; pc_source = SRC_JUMP;   taken = 1'b1; end
            K_JR:    begin pc_write = 1'b1; pc_source = SRC_ALUOUT; taken = 1'b1; end
            default: ;
          endcase
        end
        S_CALC:  alu_calc = 1'b1;
        S_EVAL:  begin
          done      = 1'b1;
          taken     = w_cond;
          pc_write  = w_cond;
          pc_source = w_cond ? SRC_ALUOUT : SRC_PC4;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pc_update_ctrl.sv
// Directed self-checking bench for pc_update_ctrl; inputs change and outputs are
// checked on the falling edge, away from the active rising edge.
module tb_pc_update_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic [2:0]  req_kind;
  logic [1:0]  br_cond;
  logic        zero;
  logic        gt;
  logic        req_ready;
  logic [2:0]  pc_source;
  logic        pc_write;
  logic        alu_calc;
  logic        done;
  logic        taken;
  logic [15:0] taken_count;

  int n_tests = 0;
  int n_fail  = 0;
  logic [15:0] exp_count;

  pc_update_ctrl dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_kind(req_kind),
    .br_cond(br_cond), .zero(zero), .gt(gt), .req_ready(req_ready),
    .pc_source(pc_source), .pc_write(pc_write), .alu_calc(alu_calc),
    .done(done), .taken(taken), .taken_count(taken_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one branch from IDLE; zero/gt carry the opposite values during CALC
  task automatic do_branch(input logic [1:0] c, input logic z, input logic g, input logic exp_t);
    req_valid = 1'b1; req_kind = 3'b011; br_cond = c; zero = ~z; gt = ~g;
    @(negedge clk);
    chk("br_calc_alu", alu_calc, 1);
    chk("br_calc_pcw", pc_write, 0);
    chk("br_calc_rdy", req_ready, 0);
    req_valid = 1'b0; req_kind = 3'b001; br_cond = ~c; zero = z; gt = g;
    @(negedge clk);
    chk("br_eval_done", done, 1);
    chk("br_eval_pcw", pc_write, exp_t);
    chk("br_eval_taken", taken, exp_t);
    chk("br_eval_src", pc_source, exp_t ? 3'b010 : 3'b000);
    chk("br_eval_alu", alu_calc, 0);
    if (exp_t && exp_count != 16'hFFFF) exp_count = exp_count + 16'd1;
    @(negedge clk);
    chk("br_count", taken_count, exp_count);
    chk("br_idle_rdy", req_ready, 1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // Taken table per br_cond, bit index = {zero, gt}: beq, bne, bgt, ble
  logic [3:0] exp_tab [4];

  initial begin
    exp_tab[0] = 4'b1100;
    exp_tab[1] = 4'b0011;
    exp_tab[2] = 4'b1010;
    exp_tab[3] = 4'b0101;
    exp_count = 16'h0000;

    // Reset held 3 cycles with a pending request
    reset = 1'b0; req_valid = 1'b1; req_kind = 3'b000; br_cond = 2'b00; zero = 1'b0; gt = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("rst_pcw", pc_write, 0);
      chk("rst_done", done, 0);
      chk("rst_count", taken_count, 0);
      chk("rst_src", pc_source, 0);
    end
    reset = 1'b1; req_valid = 1'b0;
    #1 chk("rst_ready_after", req_ready, 1);
    @(negedge clk);
    chk("rst_no_accept_done", done, 0);
    chk("rst_no_accept_rdy", req_ready, 1);

    // SEQ then JUMP back-to-back with req_valid held
    req_valid = 1'b1; req_kind = 3'b000;
    @(negedge clk);
    chk("seq_pcw", pc_write, 1);
    chk("seq_src", pc_source, 3'b000);
    chk("seq_taken", taken, 0);
    chk("seq_done", done, 1);
    chk("seq_rdy", req_ready, 0);
    req_kind = 3'b001;
    @(negedge clk);
    chk("gap_pcw", pc_write, 0);
    chk("gap_rdy", req_ready, 1);
    @(negedge clk);
    chk("jmp_pcw", pc_write, 1);
    chk("jmp_src", pc_source, 3'b011);
    chk("jmp_taken", taken, 1);
    chk("jmp_rdy", req_ready, 0);
    req_kind = 3'b010;
    @(negedge clk);
    @(negedge clk);
    chk("jr_pcw", pc_write, 1);
    chk("jr_src", pc_source, 3'b010);
    chk("jr_taken", taken, 1);
    req_valid = 1'b0;
    @(negedge clk);
    chk("jr_after_pcw", pc_write, 0);

    // beq taken then not taken
    do_branch(2'b00, 1'b1, 1'b0, 1'b1);
    do_branch(2'b00, 1'b0, 1'b0, 1'b0);

    // Full condition sweep
    for (int c = 0; c < 4; c++)
      for (int zg = 0; zg < 4; zg++)
        do_branch(c[1:0], zg[1], zg[0], exp_tab[c][zg]);

    // Invalid kind retires without PC change
    req_valid = 1'b1; req_kind = 3'b101;
    @(negedge clk);
    req_valid = 1'b0;
    chk("inv_done", done, 1);
    chk("inv_pcw", pc_write, 0);
    chk("inv_taken", taken, 0);
    chk("inv_src", pc_source, 3'b000);
    @(negedge clk);

    // Reset during CALC discards the branch and clears the count
    req_valid = 1'b1; req_kind = 3'b011; br_cond = 2'b00; zero = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    chk("rc_alu", alu_calc, 1);
    reset = 1'b0;
    #1 chk("rc_alu_gated", alu_calc, 0);
    @(negedge clk);
    chk("rc_done", done, 0);
    chk("rc_pcw", pc_write, 0);
    chk("rc_count", taken_count, 0);
    exp_count = 16'h0000;
    reset = 1'b1;
    #1 chk("rc_idle", req_ready, 1);
    @(negedge clk);
    chk("rc_done_after", done, 0);
    chk("rc_pcw_after", pc_write, 0);

    // Saturation: preload near the top, then keep taking branches
    force dut.r_taken_count = 16'hFFFD;
    @(negedge clk);
    release dut.r_taken_count;
    @(negedge clk);
    chk("sat_preload", taken_count, 16'hFFFD);
    exp_count = 16'hFFFD;
    do_branch(2'b00, 1'b1, 1'b0, 1'b1);
    do_branch(2'b00, 1'b1, 1'b0, 1'b1);
    chk("sat_top", taken_count, 16'hFFFF);
    do_branch(2'b00, 1'b1, 1'b0, 1'b1);
    do_branch(2'b01, 1'b0, 1'b0, 1'b1);
    chk("sat_hold", taken_count, 16'hFFFF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
